// File: rtl/vco_cnt_pkg.sv
// -----------------------------------------------------------------------------
// vco_cnt_pkg
//   Shared types and constants for the VCO frequency counter.
//   - state_t          : measurement FSM state (2-bit encoding)
//   - *_DEF            : default widths / timing constants
//   - settle_cnt_w()   : width of the settle-phase cycle counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package vco_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned CNT_W_DEF         = 16;
    localparam int unsigned GATE_W_DEF        = 16;
    localparam int unsigned SETTLE_CYCLES_DEF = 64;
    localparam int unsigned SYNC_STAGES_DEF   = 2;

    // Counter holds 0..n-1, so clog2(n) bits suffice; never narrower than 1.
    function automatic int unsigned settle_cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vco_edge_sync.sv
// -----------------------------------------------------------------------------
// vco_edge_sync
//   Brings the asynchronous oscillator output into the clk domain through a
//   SYNC_STAGES flop chain, then produces a one-cycle pulse per rising edge.
//   Kept as its own module so the first stage can be tagged for CDC.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   osc_i      in  raw oscillator output (asynchronous)
//   edge_pulse out one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module vco_edge_sync
    import vco_cnt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_i,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], osc_i};
            r_dly  <= w_synced;
        end
    end

    assign edge_pulse = w_synced & ~r_dly;

endmodule

// File: rtl/vco_freq_counter.sv
// -----------------------------------------------------------------------------
// vco_freq_counter
//   Reads an on-chip VCO: releases the oscillator from reset, lets it settle
//   for SETTLE_CYCLES clocks, counts synchronized rising edges over a gate of
//   gate_len_i clocks (0 treated as 1) and offers the saturating count with a
//   valid/ready handshake.
//   Optional feature macro: VCO_CNT_CONT_EN (continuous re-measurement after
//   each handshake until start_i is seen while a result is pending).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           request a measurement (honoured in IDLE only)
//   gate_len_i        gate length in clk cycles, latched on start
//   osc_i             raw oscillator output (asynchronous)
//   osc_rst_o         high holds the oscillator stopped
//   busy_o            measurement in progress (SETTLE/GATE)
//   result_o, ovf_o   last count and its saturation flag
//   result_valid_o    result_o/ovf_o valid
//   result_ready_i    consumer accepts the result
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module vco_freq_counter
    import vco_cnt_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned GATE_W        = GATE_W_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [GATE_W-1:0] gate_len_i,
    input  logic              osc_i,
    output logic              osc_rst_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  result_o,
    output logic              ovf_o,
    output logic              result_valid_o,
    input  logic              result_ready_i
);

    localparam int unsigned      SET_W       = settle_cnt_w(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [GATE_W-1:0]  r_gate_len;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_run;
    logic [CNT_W-1:0]   r_result;
    logic               r_ovf;

    logic               w_edge_pulse;
    logic               w_settle_last;
    logic               w_gate_last;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_ovf_next;

`ifdef VCO_CNT_CONT_EN
    logic               r_cont_stop;
`endif

    vco_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .osc_i      (osc_i),
        .edge_pulse (w_edge_pulse)
    );

    assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
    assign w_gate_last   = (r_gate_cnt == (r_gate_len - GATE_W'(1)));

    // Saturating edge counter: an edge arriving at all-ones flags overflow.
    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf_run;
        if (w_edge_pulse) begin
            if (&r_cnt) begin
                w_ovf_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        osc_rst_o      = 1'b1;
        busy_o         = 1'b0;
        result_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                osc_rst_o = 1'b0;
                busy_o    = 1'b1;
                if (w_settle_last) begin
                    w_state_next = GATE;
                end
            end
            GATE: begin
                osc_rst_o = 1'b0;
                busy_o    = 1'b1;
                if (w_gate_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
`ifdef VCO_CNT_CONT_EN
                    w_state_next = (r_cont_stop | start_i) ? IDLE : SETTLE;
`else
                    w_state_next = IDLE;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Counters are cleared whenever the FSM is in IDLE or DONE, so every
    // entry into SETTLE (from start or continuous restart) begins from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_gate_len   <= '0;
            r_gate_cnt   <= '0;
            r_cnt        <= '0;
            r_ovf_run    <= 1'b0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_settle_cnt <= '0;
                    r_cnt        <= '0;
                    r_ovf_run    <= 1'b0;
                    if (start_i) begin
                        r_gate_len <= (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
                    end
                end
                SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    r_gate_cnt   <= '0;
                end
                GATE: begin
                    r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                    r_cnt      <= w_cnt_next;
                    r_ovf_run  <= w_ovf_next;
                    // Result includes an edge on the final gate cycle.
                    if (w_gate_last) begin
                        r_result <= w_cnt_next;
                        r_ovf    <= w_ovf_next;
                    end
                end
                DONE: begin
                    r_settle_cnt <= '0;
                    r_cnt        <= '0;
                    r_ovf_run    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef VCO_CNT_CONT_EN
    // Remembers a stop request seen at any point while the result is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cont_stop <= 1'b0;
        end else if (r_state == DONE) begin
            if (result_ready_i) begin
                r_cont_stop <= 1'b0;
            end else if (start_i) begin
                r_cont_stop <= 1'b1;
            end
        end else begin
            r_cont_stop <= 1'b0;
        end
    end
`endif

    assign result_o = r_result;
    assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_vco_freq_counter.sv
`timescale 1ns/1ps
module tb_vco_freq_counter;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GATE_W = 16;
    localparam int unsigned SETTLE = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [GATE_W-1:0] gate_len_i = '0;
    logic              osc_i = 1'b0;
    logic              osc_rst_o;
    logic              busy_o;
    logic [CNT_W-1:0]  result_o;
    logic              ovf_o;
    logic              result_valid_o;
    logic              result_ready_i = 1'b0;

    int n_tot = 0;
    int n_bad = 0;

    bit osc_run = 1'b0;
    int osc_half = 50;

    vco_freq_counter #(
        .CNT_W         (CNT_W),
        .GATE_W        (GATE_W),
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .gate_len_i     (gate_len_i),
        .osc_i          (osc_i),
        .osc_rst_o      (osc_rst_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .ovf_o          (ovf_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i)
    );

    always #5 clk = ~clk;

    always begin
        if (osc_run) begin
            #(osc_half) osc_i = ~osc_i;
        end else begin
            #1;
        end
    end

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned clampv(input int unsigned v, input int unsigned lo, input int unsigned hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Start a measurement and wait for result_valid_o; cyc counts clock edges
    // from the start-accepting edge (1) to the edge that raises valid.
    task automatic meas(input logic [GATE_W-1:0] gl, output int cyc,
                        output logic [CNT_W-1:0] res, output logic ov,
                        output logic busy10, output logic oscrst10);
        @(negedge clk);
        gate_len_i = gl;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc     = 1;
        busy10   = 1'b0;
        oscrst10 = 1'b1;
        while (!result_valid_o && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                busy10   = busy_o;
                oscrst10 = osc_rst_o;
            end
        end
        res = result_o;
        ov  = ovf_o;
    endtask

    task automatic ack();
        @(negedge clk);
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
    endtask

    int               cyc;
    logic [CNT_W-1:0] res;
    logic             ov;
    logic             b10;
    logic             r10;
    int               nchg;
    int               nval;
    logic [CNT_W-1:0] saved;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_osc_rst", osc_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", result_valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst = 1'b0;
        #3 osc_run = 1'b1;

`ifdef VCO_CNT_CONT_EN
        begin
            int run;
            int nres;
            osc_half       = 100;
            result_ready_i = 1'b1;
            @(negedge clk);
            gate_len_i = 16'd200;
            start_i    = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            run  = 0;
            nres = 0;
            for (int i = 0; i < 3000 && nres < 3; i++) begin
                @(negedge clk);
                if (osc_rst_o) begin
                    run++;
                end else begin
                    if (run > 0 && nres >= 1) chk("cont_gap", run, 1);
                    run = 0;
                end
                if (result_valid_o) begin
                    nres++;
                    chk("cont_result", result_o, clampv(result_o, 9, 11));
                    chk("cont_ovf", ovf_o, 0);
                    if (nres == 3) start_i = 1'b1;
                end
            end
            chk("cont_nres", nres, 3);
            @(negedge clk);
            start_i = 1'b0;
            repeat (5) @(negedge clk);
            chk("cont_stop_busy", busy_o, 0);
            chk("cont_stop_oscrst", osc_rst_o, 1);
            result_ready_i = 1'b0;
        end
`else
        // Nominal: osc period 10 clk, 1000-cycle gate.
        osc_half = 50;
        meas(16'd1000, cyc, res, ov, b10, r10);
        chk("nom_latency", cyc, SETTLE + 1000 + 1);
        chk("nom_result", res, clampv(res, 99, 101));
        chk("nom_ovf", ov, 0);
        chk("nom_busy", b10, 1);
        chk("nom_osc_rst", r10, 0);

        // Backpressure with ignored start pulses.
        saved = result_o;
        nchg  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start_i = (i == 10 || i == 30);
            if (result_o !== saved || result_valid_o !== 1'b1 || osc_rst_o !== 1'b1) nchg++;
        end
        chk("bp_stable", nchg, 0);
        // Handshake with a coincident start: start must be ignored.
        result_ready_i = 1'b1;
        start_i        = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
        start_i        = 1'b0;
        chk("hs_valid_drop", result_valid_o, 0);
        chk("hs_busy", busy_o, 0);
        chk("hs_osc_rst", osc_rst_o, 1);
        chk("hs_result_hold", result_o, saved);
        @(negedge clk);
        chk("hs_start_ignored", busy_o, 0);

        // Saturation: osc period 3 clk -> 333 edges into an 8-bit counter.
        osc_half = 15;
        meas(16'd1000, cyc, res, ov, b10, r10);
        chk("sat_result", res, 255);
        chk("sat_ovf", ov, 1);
        ack();

        // gate_len_i = 0 behaves as a one-cycle gate.
        osc_half = 50;
        meas(16'd0, cyc, res, ov, b10, r10);
        chk("gate0_latency", cyc, SETTLE + 1 + 1);
        chk("gate0_result", res, clampv(res, 0, 1));
        ack();

        // osc held high before start: its edge is consumed outside GATE.
        osc_run = 1'b0;
        #20;
        osc_i = 1'b1;
        repeat (10) @(negedge clk);
        meas(16'd100, cyc, res, ov, b10, r10);
        chk("high_result", res, 0);
        chk("high_ovf", ov, 0);
        ack();

        // Reset in the middle of GATE with osc toggling.
        osc_i = 1'b0;
        #3 osc_run = 1'b1;
        @(negedge clk);
        gate_len_i = 16'd1000;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (SETTLE + 100) @(negedge clk);
        chk("mid_gate_busy", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_osc_rst", osc_rst_o, 1);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_valid", result_valid_o, 0);
        @(negedge clk);
        rst  = 1'b0;
        nval = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (result_valid_o) nval++;
        end
        chk("mrst_no_result", nval, 0);
        chk("mrst_idle", busy_o, 0);
`endif

        osc_run = 1'b0;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
